io_frontend: RTL and testbench
==============================

# io_frontend

Board-side input stage feeding the picoMIPS core. It synchronises and debounces the raw handshake pushbutton. It converts each accepted press into a single-cycle `io_handshake` pulse. On the same clock edge it snapshots the synchronised data switches onto `in_bus`, so the core's LD instruction sees a value that is stable for the whole instruction. Sits directly upstream of the processor's `in_bus`/`io_handshake` inputs.

## Interface
Parameters:
- `N`, 8, data width; must match the processor's `N`.
- `DebounceCycles`, 16, consecutive stable cycles required to accept a press or release; legal range ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_raw`  in  1  raw pushbutton, asynchronous, high = pressed.
- `sw_raw`  in  N  raw data switches, asynchronous.
- `in_bus`  out  N  registered switch snapshot to processor `in_bus`.
- `io_handshake`  out  1  registered one-cycle pulse per accepted press.
- `press_count`  out  8  registered count of accepted presses; wraps.

## Operation
- Synchronisers:
  - `btn_raw` passes through a 2-FF synchroniser to produce `btn_s`.
  - `sw_raw` passes through a parallel N-bit 2-FF synchroniser to produce `sw_s`.
  - The FSM uses only `btn_s` and `sw_s`.
- Debounce counter width is `$clog2(DebounceCycles)`. The counter clears on every state change.
- FSM states and transitions:
  - IDLE: `btn_s`=1 → PRESS_WAIT.
  - PRESS_WAIT:
    - `btn_s`=0 → IDLE (bounce rejected, no pulse).
    - `btn_s`=1 with count = `DebounceCycles`-1 → HELD.
    - Otherwise count increments.
  - HELD: `btn_s`=0 → RELEASE_WAIT.
  - RELEASE_WAIT:
    - `btn_s`=1 → HELD (no pulse).
    - `btn_s`=0 with count = `DebounceCycles`-1 → IDLE.
    - Otherwise count increments.
- On the edge that enters HELD from PRESS_WAIT:
  - `io_handshake` ← 1.
  - `in_bus` ← `sw_s`.
  - `press_count` ← `press_count`+1, modulo 256 (255 → 0).
- Every other edge: `io_handshake` ← 0; `in_bus` and `press_count` hold.
- Holding the button produces exactly one pulse. A new pulse requires a full release (back to IDLE) and then a new press.
- Switch changes while in HELD do not affect `in_bus` until the next accepted press.

## Timing
- Reset (async assert, sync deassert by the system):
  - `in_bus`=0, `io_handshake`=0, `press_count`=0.
  - State IDLE, counter 0, all synchroniser flops 0.
- Reset mid-operation: the FSM returns to IDLE immediately. A button still held after reset release counts as a new press after full synchroniser and debounce latency.
- Press latency with debounce enabled: `btn_raw` high and stable from before edge 0 means `btn_s`=1 after edge 1, PRESS_WAIT after edge 2, and `io_handshake`=1 after edge `DebounceCycles`+2 for exactly one cycle. With the default this is edge 18.
- `in_bus` changes only on the pulse edge. The captured value is `sw_raw` as sampled at least 2 edges earlier.
- Glitches on `btn_raw` shorter than `DebounceCycles` cycles never produce a pulse.

## Configuration
- `PICO_IO_DEBOUNCE_EN` defined:
  - Full four-state FSM with debounce counter, as above.
- `PICO_IO_DEBOUNCE_EN` undefined:
  - Counter and the PRESS_WAIT/RELEASE_WAIT states are removed.
  - IDLE goes to HELD on `btn_s`=1, asserting the pulse, capture and count at that edge; `io_handshake`=1 after edge 2.
  - HELD goes to IDLE on `btn_s`=0.
  - `DebounceCycles` is ignored.
  - Synchronisers are retained.

## Test plan
- Clean press: `sw_raw`=8'hA5, `btn_raw` held high 40 cycles → one `io_handshake` pulse after edge 18, `in_bus`=8'hA5, `press_count`=1.
- Bounce reject: `btn_raw` high 10 cycles then low, repeated 3 times → no pulse, `in_bus`=0, `press_count`=0.
- Release bounce: after an accepted press, `btn_raw` low 5 cycles then high 20 cycles then low 30 cycles → no second pulse, `press_count` stays 1, FSM ends in IDLE.
- Capture hold: accepted press with `sw_raw`=8'h3C, then `sw_raw`=8'hFF while held → `in_bus` stays 8'h3C; next press captures 8'hFF.
- Wrap and reset: 256 clean presses → `press_count`=0. Then assert `reset` in PRESS_WAIT → all outputs 0 immediately and no pulse.
- Macro off: same stimulus as clean press → pulse after edge 2, `in_bus`=8'hA5.

Source files
------------

// File: rtl/io_frontend.sv
// io_frontend: synchronises the handshake button and switches, emits one io_handshake pulse per
// accepted press and snapshots the switches onto in_bus. Define PICO_IO_DEBOUNCE_EN for the debounce FSM.
module io_frontend #(
    parameter int N              = 8,
    parameter int DebounceCycles = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         btn_raw,
    input  logic [N-1:0] sw_raw,
    output logic [N-1:0] in_bus,
    output logic         io_handshake,
    output logic [7:0]   press_count
);

    if (DebounceCycles < 2) begin : g_bad_debounce
        $error("io_frontend: DebounceCycles must be at least 2");
    end

    logic         btn_p0;
    logic         btn_s;
    logic [N-1:0] sw_p0;
    logic [N-1:0] sw_s;
    logic         accept;

    // Stage p0 -> s: two-flop synchronisers, switches aligned with the button
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_p0 <= 1'b0;
            btn_s  <= 1'b0;
            sw_p0  <= '0;
            sw_s   <= '0;
        end else begin
            btn_p0 <= btn_raw;
            btn_s  <= btn_p0;
            sw_p0  <= sw_raw;
            sw_s   <= sw_p0;
        end
    end

`ifdef PICO_IO_DEBOUNCE_EN
    localparam int            CW      = $clog2(DebounceCycles);
    localparam logic [CW-1:0] CntLast = CW'(DebounceCycles - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: if (btn_s) state_next = PRESS_WAIT;
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_next = IDLE;
                end else if (cnt == CntLast) begin
                    state_next = HELD;
                    accept     = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            HELD: if (!btn_s) state_next = RELEASE_WAIT;
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_next = HELD;
                end else if (cnt == CntLast) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // Every wait state starts its stability count from zero
        if (state_next != state) cnt_next = '0;
    end
`else
    typedef enum logic {IDLE, HELD} state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next = HELD;
                    accept     = 1'b1;
                end
            end
            HELD: if (!btn_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
`endif

    // Stage s -> out: pulse, snapshot and count all land on the accepting edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_bus       <= '0;
            io_handshake <= 1'b0;
            press_count  <= '0;
        end else begin
            io_handshake <= accept;
            if (accept) begin
                in_bus      <= sw_s;
                press_count <= press_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_io_frontend.sv
// tb_io_frontend: directed, table-driven bench for io_frontend in either build
// (PICO_IO_DEBOUNCE_EN defined or not).
module tb_io_frontend;

`ifdef PICO_IO_DEBOUNCE_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_raw;
    logic [7:0] sw_raw;
    logic [7:0] in_bus;
    logic       io_handshake;
    logic [7:0] press_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       btn;
        logic [7:0] sw;
        int         cycles;
        int         pulses;
        logic [7:0] exp_bus;
        logic [7:0] exp_count;
    } vec_t;

    vec_t tbl[$];

    io_frontend #(.N(8), .DebounceCycles(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .sw_raw      (sw_raw),
        .in_bus      (in_bus),
        .io_handshake(io_handshake),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic b, input logic [7:0] s, input int c,
                                input int p, input logic [7:0] eb, input logic [7:0] ec);
        vec_t v;
        v.btn = b; v.sw = s; v.cycles = c; v.pulses = p; v.exp_bus = eb; v.exp_count = ec;
        return v;
    endfunction

    // Runs max cycles, reporting the edge index of the first pulse and the pulse total
    task automatic measure(input int max, output int first, output int n);
        first = -1;
        n = 0;
        for (int j = 0; j < max; j++) begin
            @(posedge clk); #1;
            if (io_handshake === 1'b1) begin
                if (n == 0) first = j;
                n++;
            end
        end
    endtask

    task automatic do_reset();
        btn_raw = 1'b0;
        reset   = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("reset_in_bus", in_bus, 0);
        check("reset_handshake", io_handshake, 0);
        check("reset_press_count", press_count, 0);
        reset = 1'b0;
    endtask

    task automatic run_table(input string tag);
        int first, n;
        for (int i = 0; i < tbl.size(); i++) begin
            btn_raw = tbl[i].btn;
            sw_raw  = tbl[i].sw;
            measure(tbl[i].cycles, first, n);
            check($sformatf("%s[%0d]_pulses", tag, i), n, tbl[i].pulses);
            check($sformatf("%s[%0d]_in_bus", tag, i), in_bus, tbl[i].exp_bus);
            check($sformatf("%s[%0d]_press_count", tag, i), press_count, tbl[i].exp_count);
        end
        tbl.delete();
    endtask

    initial begin
        int first, n, total;
        reset   = 1'b1;
        btn_raw = 1'b0;
        sw_raw  = 8'h00;

        // Bounce rejection: three 10-cycle highs
        do_reset();
        for (int r = 0; r < 3; r++) begin
`ifdef PICO_IO_DEBOUNCE_EN
            tbl.push_back(mk(1'b1, 8'h5A, 10, 0, 8'h00, 8'd0));
            tbl.push_back(mk(1'b0, 8'h5A, 10, 0, 8'h00, 8'd0));
`else
            tbl.push_back(mk(1'b1, 8'h5A, 10, 1, 8'h5A, 8'(r + 1)));
            tbl.push_back(mk(1'b0, 8'h5A, 10, 0, 8'h5A, 8'(r + 1)));
`endif
        end
        run_table("bounce");

        // Clean press: exact latency and a single pulse while held
        do_reset();
        sw_raw  = 8'hA5;
        btn_raw = 1'b1;
        measure(40, first, n);
        check("clean_pulse_edge", first, LAT);
        check("clean_pulse_total", n, 1);
        check("clean_in_bus", in_bus, 8'hA5);
        check("clean_press_count", press_count, 1);

        // Release bounce, then a fresh press proves the FSM went back to idle
`ifdef PICO_IO_DEBOUNCE_EN
        tbl.push_back(mk(1'b0, 8'hA5, 5, 0, 8'hA5, 8'd1));
        tbl.push_back(mk(1'b1, 8'hA5, 20, 0, 8'hA5, 8'd1));
        tbl.push_back(mk(1'b0, 8'hA5, 30, 0, 8'hA5, 8'd1));
        tbl.push_back(mk(1'b1, 8'h77, 40, 1, 8'h77, 8'd2));
        tbl.push_back(mk(1'b0, 8'h77, 30, 0, 8'h77, 8'd2));
`else
        tbl.push_back(mk(1'b0, 8'hA5, 5, 0, 8'hA5, 8'd1));
        tbl.push_back(mk(1'b1, 8'hA5, 20, 1, 8'hA5, 8'd2));
        tbl.push_back(mk(1'b0, 8'hA5, 30, 0, 8'hA5, 8'd2));
        tbl.push_back(mk(1'b1, 8'h77, 40, 1, 8'h77, 8'd3));
        tbl.push_back(mk(1'b0, 8'h77, 30, 0, 8'h77, 8'd3));
`endif
        run_table("release");

        // Capture hold: switch changes while held are ignored until the next press
        do_reset();
        tbl.push_back(mk(1'b1, 8'h3C, 40, 1, 8'h3C, 8'd1));
        tbl.push_back(mk(1'b1, 8'hFF, 20, 0, 8'h3C, 8'd1));
        tbl.push_back(mk(1'b0, 8'hFF, 30, 0, 8'h3C, 8'd1));
        tbl.push_back(mk(1'b1, 8'hFF, 40, 1, 8'hFF, 8'd2));
        tbl.push_back(mk(1'b0, 8'hFF, 30, 0, 8'hFF, 8'd2));
        run_table("capture");

        // Counter wrap over 256 presses
        do_reset();
        sw_raw = 8'hC3;
        total  = 0;
        for (int p = 0; p < 256; p++) begin
            btn_raw = 1'b1;
            measure(LAT + 3, first, n);
            total += n;
            if (p == 254) check("wrap_count_255", press_count, 255);
            btn_raw = 1'b0;
            measure(LAT + 3, first, n);
            total += n;
        end
        check("wrap_pulse_total", total, 256);
        check("wrap_count_0", press_count, 0);
        check("wrap_in_bus", in_bus, 8'hC3);

        // Async reset mid-press clears outputs at once; the held button is a new press afterwards
        btn_raw = 1'b1;
        measure(5, first, n);
        reset = 1'b1;
        #1;
        check("async_in_bus", in_bus, 0);
        check("async_handshake", io_handshake, 0);
        check("async_press_count", press_count, 0);
        measure(2, first, n);
        check("async_no_pulse_in_reset", n, 0);
        reset = 1'b0;
        measure(LAT + 10, first, n);
        check("post_reset_pulse_edge", first, LAT);
        check("post_reset_pulse_total", n, 1);
        check("post_reset_press_count", press_count, 1);
        check("post_reset_in_bus", in_bus, 8'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
